// File: rtl/router_pkg.sv
// Shared types and default sizing for the multi-destination router.
package router_pkg;

   localparam int DEF_DATA_WIDTH = 6;
   localparam int DEF_NUM_DEST   = 2;
   localparam int DEF_FIFO_DEPTH = 8;

   typedef enum logic [2:0] {
      ST_RESET,
      ST_INIT,
      ST_IDLE,
      ST_ACTIVE,
      ST_ERROR
   } router_state_t;

endpackage

// File: rtl/multi_dest_router_if.sv
// Push/pop bus of the router: write side, per-destination pops, heads and flags.
interface multi_dest_router_if
   import router_pkg::*;
#(
   parameter int DATA_WIDTH = DEF_DATA_WIDTH,
   parameter int NUM_DEST   = DEF_NUM_DEST
);

   logic                           wr_enable;
   logic [DATA_WIDTH-1:0]          data_in;
   logic [NUM_DEST-1:0]            pop;
   logic [DATA_WIDTH*NUM_DEST-1:0] data_out;
   logic [NUM_DEST-1:0]            empty;
   logic [NUM_DEST-1:0]            almost_full;
   logic [NUM_DEST-1:0]            almost_empty;
   logic [NUM_DEST-1:0]            error;
   logic                           pause;

   modport master (
      output wr_enable, data_in, pop,
      input  data_out, empty, almost_full, almost_empty, error, pause
   );

   modport slave (
      input  wr_enable, data_in, pop,
      output data_out, empty, almost_full, almost_empty, error, pause
   );

endinterface

// File: rtl/fifo_sync.sv
// Single-clock FIFO with a registered head word and threshold flags from the count.
module fifo_sync
   import router_pkg::*;
#(
   parameter  int DATA_WIDTH = DEF_DATA_WIDTH,
   parameter  int FIFO_DEPTH = DEF_FIFO_DEPTH,
   localparam int AW         = $clog2(FIFO_DEPTH),
   localparam int CW         = AW + 1
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  flush_i,
   input  logic                  push_i,
   input  logic                  pop_i,
   input  logic [DATA_WIDTH-1:0] din_i,
   input  logic [CW-1:0]         af_i,
   input  logic [CW-1:0]         ae_i,
   output logic [CW-1:0]         count_o,
   output logic [DATA_WIDTH-1:0] head_o,
   output logic                  empty_o,
   output logic                  full_o,
   output logic                  almost_full_o,
   output logic                  almost_empty_o
);

   logic [DATA_WIDTH-1:0] mem_q [FIFO_DEPTH];
   logic [AW-1:0]         wr_q, rd_q;
   logic [CW-1:0]         cnt_q;
   logic [DATA_WIDTH-1:0] head_q;
   logic                  pop_ok, push_ok;
   logic [CW-1:0]         af_thr;

   // A full FIFO still takes a push when the same cycle frees a slot.
   assign pop_ok  = pop_i && (cnt_q != '0);
   assign push_ok = push_i && ((cnt_q != CW'(FIFO_DEPTH)) || pop_ok);

   always_ff @(posedge clk) begin
      if (push_ok && !flush_i) begin
         mem_q[wr_q] <= din_i;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         wr_q   <= '0;
         rd_q   <= '0;
         cnt_q  <= '0;
         head_q <= '0;
      end else if (flush_i) begin
         wr_q  <= '0;
         rd_q  <= '0;
         cnt_q <= '0;
      end else begin
         if (push_ok) begin
            wr_q <= wr_q + AW'(1);
         end
         if (pop_ok) begin
            head_q <= mem_q[rd_q];
            rd_q   <= rd_q + AW'(1);
         end
         if (push_ok && !pop_ok) begin
            cnt_q <= cnt_q + CW'(1);
         end else if (pop_ok && !push_ok) begin
            cnt_q <= cnt_q - CW'(1);
         end
      end
   end

   assign af_thr = (af_i >= CW'(FIFO_DEPTH)) ? '0 : CW'(FIFO_DEPTH) - af_i;

   assign count_o        = cnt_q;
   assign head_o         = head_q;
   assign empty_o        = (cnt_q == '0);
   assign full_o         = (cnt_q == CW'(FIFO_DEPTH));
   assign almost_full_o  = (cnt_q >= af_thr);
   assign almost_empty_o = (cnt_q <= ae_i);

endmodule

// File: rtl/multi_dest_router.sv
// Routes each pushed word to the FIFO selected by its top bits; sequencing FSM in this file.
// Optional ROUTER_ERR_CLR_EN adds err_clr_i to leave ERROR (clears errors, flushes FIFOs).
//   state  | meaning
//   RESET  | after reset, waiting for init rising edge
//   INIT   | one cycle, latch thresholds
//   IDLE   | accepting pushes, nothing in flight
//   ACTIVE | accepting pushes, data buffered
//   ERROR  | overflow/underflow seen, pushes dropped
module multi_dest_router
   import router_pkg::*;
#(
   parameter  int DATA_WIDTH = DEF_DATA_WIDTH,
   parameter  int NUM_DEST   = DEF_NUM_DEST,
   parameter  int FIFO_DEPTH = DEF_FIFO_DEPTH,
   localparam int CW         = $clog2(FIFO_DEPTH) + 1,
   localparam int DB         = $clog2(NUM_DEST)
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       init_i,
   input  logic [CW-1:0]              umbral_af_i,
   input  logic [CW-1:0]              umbral_ae_i,
`ifdef ROUTER_ERR_CLR_EN
   input  logic                       err_clr_i,
`endif
   multi_dest_router_if.slave         bus,
   output logic                       idle_out_o,
   output logic                       active_out_o,
   output logic                       error_out_o
);

   router_state_t         state_q, state_d;
   logic                  init_q;
   logic [CW-1:0]         af_q, ae_q;
   logic [NUM_DEST-1:0]   err_q, err_d;
   logic [DB-1:0]         dest;
   logic                  push_en, pop_en, init_rise, flush, err_ev, all_drained;
   logic [NUM_DEST-1:0]   push_req, pop_req, ovf, udf, drain_nx;
   logic [NUM_DEST-1:0]   full, empty, af, ae;
   logic [CW-1:0]         cnt  [NUM_DEST];
   logic [DATA_WIDTH-1:0] head [NUM_DEST];

   assign dest      = bus.data_in[DATA_WIDTH-1 -: DB];
   assign init_rise = init_i && !init_q;
   assign push_en   = bus.wr_enable && ((state_q == ST_IDLE) || (state_q == ST_ACTIVE));
   assign pop_en    = (state_q == ST_IDLE) || (state_q == ST_ACTIVE) || (state_q == ST_ERROR);

`ifdef ROUTER_ERR_CLR_EN
   assign flush = (state_q == ST_ERROR) && err_clr_i;
`else
   assign flush = 1'b0;
`endif

   for (genvar g = 0; g < NUM_DEST; g++) begin : g_dest
      assign push_req[g] = push_en && (dest == DB'(g));
      assign pop_req[g]  = pop_en && !flush && bus.pop[g];
      assign ovf[g]      = push_req[g] && full[g] && !pop_req[g];
      assign udf[g]      = pop_req[g] && empty[g];
      assign drain_nx[g] = empty[g] || ((cnt[g] == CW'(1)) && pop_req[g]);

      fifo_sync #(
         .DATA_WIDTH (DATA_WIDTH),
         .FIFO_DEPTH (FIFO_DEPTH)
      ) u_fifo (
         .clk            (clk),
         .reset          (reset),
         .flush_i        (flush),
         .push_i         (push_req[g]),
         .pop_i          (pop_req[g]),
         .din_i          (bus.data_in),
         .af_i           (af_q),
         .ae_i           (ae_q),
         .count_o        (cnt[g]),
         .head_o         (head[g]),
         .empty_o        (empty[g]),
         .full_o         (full[g]),
         .almost_full_o  (af[g]),
         .almost_empty_o (ae[g])
      );
   end

   assign err_ev      = |(ovf | udf);
   assign all_drained = &drain_nx;
   assign err_d       = flush ? '0 : (err_q | ovf | udf);

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_RESET:  if (init_rise) state_d = ST_INIT;
         ST_INIT:   state_d = ST_IDLE;
         ST_IDLE: begin
            if (err_ev)         state_d = ST_ERROR;
            else if (init_rise) state_d = ST_INIT;
            else if (push_en)   state_d = ST_ACTIVE;
         end
         ST_ACTIVE: begin
            if (err_ev)                       state_d = ST_ERROR;
            else if (!push_en && all_drained) state_d = ST_IDLE;
         end
         ST_ERROR:  if (flush) state_d = ST_IDLE;
         default:   state_d = ST_RESET;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= ST_RESET;
         init_q  <= 1'b0;
         af_q    <= '0;
         ae_q    <= '0;
         err_q   <= '0;
      end else begin
         state_q <= state_d;
         init_q  <= init_i;
         err_q   <= err_d;
         if (state_q == ST_INIT) begin
            af_q <= umbral_af_i;
            ae_q <= umbral_ae_i;
         end
      end
   end

   always_comb begin
      bus.data_out = '0;
      for (int i = 0; i < NUM_DEST; i++) begin
         bus.data_out[i*DATA_WIDTH +: DATA_WIDTH] = head[i];
      end
   end

   assign bus.empty        = empty;
   assign bus.almost_full  = af;
   assign bus.almost_empty = ae;
   assign bus.error        = err_q;
   assign bus.pause        = |af;

   assign idle_out_o   = (state_q == ST_IDLE);
   assign active_out_o = (state_q == ST_ACTIVE);
   assign error_out_o  = (state_q == ST_ERROR);

endmodule

// File: tb/tb_multi_dest_router.sv
// Directed bench for multi_dest_router with a queue-based reference model checked every cycle.
module tb_multi_dest_router;
   import router_pkg::*;

   localparam int DW    = 6;
   localparam int ND    = 2;
   localparam int DEPTH = 8;
   localparam int CW    = $clog2(DEPTH) + 1;
`ifdef ROUTER_ERR_CLR_EN
   localparam bit HAS_CLR = 1'b1;
`else
   localparam bit HAS_CLR = 1'b0;
`endif

   localparam int M_RST = 0, M_LOAD = 1, M_IDLE = 2, M_BUSY = 3, M_FAULT = 4;

   logic          clk = 1'b0;
   logic          reset = 1'b1;
   logic          init = 1'b0;
   logic [CW-1:0] uaf = '0;
   logic [CW-1:0] uae = '0;
   logic          err_clr = 1'b0;
   logic          idle_o, act_o, err_o;

   int n_checks = 0;
   int n_fail   = 0;

   multi_dest_router_if #(.DATA_WIDTH(DW), .NUM_DEST(ND)) bus ();

   multi_dest_router #(
      .DATA_WIDTH (DW),
      .NUM_DEST   (ND),
      .FIFO_DEPTH (DEPTH)
   ) dut (
      .clk          (clk),
      .reset        (reset),
      .init_i       (init),
      .umbral_af_i  (uaf),
      .umbral_ae_i  (uae),
`ifdef ROUTER_ERR_CLR_EN
      .err_clr_i    (err_clr),
`endif
      .bus          (bus),
      .idle_out_o   (idle_o),
      .active_out_o (act_o),
      .error_out_o  (err_o)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   // Reference model: one queue per destination, mode tracked from the documented rules.
   typedef logic [DW-1:0] word_t;
   word_t       mq [ND][$];
   word_t       m_out [ND];
   logic [ND-1:0] m_err;
   int          m_af, m_ae, m_mode;
   logic        m_init_prev;
   bit          m_valid = 1'b0;

   always @(posedge clk) begin
      int nxt, d;
      bit evt, all_empty, rise, flush, busy, pops;
      if (reset) begin
         for (int i = 0; i < ND; i++) begin
            mq[i].delete();
            m_out[i] = '0;
         end
         m_err = '0; m_af = 0; m_ae = 0; m_init_prev = 1'b0; m_mode = M_RST;
      end else begin
         busy  = (m_mode == M_IDLE) || (m_mode == M_BUSY);
         pops  = busy || (m_mode == M_FAULT);
         rise  = init && !m_init_prev;
         flush = HAS_CLR && (m_mode == M_FAULT) && err_clr;
         evt   = 1'b0;
         nxt   = m_mode;
         if (flush) begin
            for (int i = 0; i < ND; i++) mq[i].delete();
            m_err = '0;
            nxt   = M_IDLE;
         end else begin
            if (pops) begin
               for (int i = 0; i < ND; i++) begin
                  if (bus.pop[i]) begin
                     if (mq[i].size() == 0) begin
                        m_err[i] = 1'b1; evt = 1'b1;
                     end else begin
                        m_out[i] = mq[i].pop_front();
                     end
                  end
               end
            end
            if (busy && bus.wr_enable) begin
               d = int'(bus.data_in) >> (DW - $clog2(ND));
               if (mq[d].size() == DEPTH) begin
                  m_err[d] = 1'b1; evt = 1'b1;
               end else begin
                  mq[d].push_back(bus.data_in);
               end
            end
            all_empty = 1'b1;
            for (int i = 0; i < ND; i++) if (mq[i].size() != 0) all_empty = 1'b0;
            case (m_mode)
               M_RST:  if (rise) nxt = M_LOAD;
               M_LOAD: begin m_af = int'(uaf); m_ae = int'(uae); nxt = M_IDLE; end
               M_IDLE: begin
                  if (evt)                  nxt = M_FAULT;
                  else if (rise)            nxt = M_LOAD;
                  else if (bus.wr_enable)   nxt = M_BUSY;
               end
               M_BUSY: begin
                  if (evt)                               nxt = M_FAULT;
                  else if (!bus.wr_enable && all_empty)  nxt = M_IDLE;
               end
               default: ;
            endcase
         end
         m_mode      = nxt;
         m_init_prev = init;
      end
      m_valid = 1'b1;
   end

   always @(negedge clk) begin
      logic [DW*ND-1:0] e_dout;
      logic [ND-1:0]    e_emp, e_af, e_ae;
      int thr;
      if (m_valid) begin
         thr = (m_af >= DEPTH) ? 0 : DEPTH - m_af;
         for (int i = 0; i < ND; i++) begin
            e_dout[i*DW +: DW] = m_out[i];
            e_emp[i] = (mq[i].size() == 0);
            e_af[i]  = (mq[i].size() >= thr);
            e_ae[i]  = (mq[i].size() <= m_ae);
         end
         chk("model data_out",     bus.data_out,     e_dout);
         chk("model empty",        bus.empty,        e_emp);
         chk("model almost_full",  bus.almost_full,  e_af);
         chk("model almost_empty", bus.almost_empty, e_ae);
         chk("model error",        bus.error,        m_err);
         chk("model pause",        bus.pause,        |e_af);
         chk("model status", {idle_o, act_o, err_o},
             {m_mode == M_IDLE, m_mode == M_BUSY, m_mode == M_FAULT});
      end
   end

   task automatic drive(input logic w, input logic [DW-1:0] d, input logic [ND-1:0] p);
      bus.wr_enable = w;
      bus.data_in   = d;
      bus.pop       = p;
      @(negedge clk);
      bus.wr_enable = 1'b0;
      bus.pop       = '0;
   endtask

   task automatic do_init();
      reset = 1'b1; init = 1'b0; uaf = CW'(1); uae = CW'(2);
      repeat (2) drive(1'b0, '0, '0);
      chk("reset status", {idle_o, act_o, err_o}, 3'b000);
      chk("reset error", bus.error, 2'b00);
      reset = 1'b0;
      drive(1'b0, '0, '0);
      init = 1'b1;
      drive(1'b0, '0, '0);
      chk("init one cycle", {idle_o, act_o, err_o}, 3'b000);
      drive(1'b0, '0, '0);
      chk("init to idle", {idle_o, act_o, err_o}, 3'b100);
   endtask

   initial begin
      bus.wr_enable = 1'b0;
      bus.data_in   = '0;
      bus.pop       = '0;

      // reset values, then threshold load
      repeat (4) @(negedge clk);
      chk("rst empty",        bus.empty,        2'b11);
      chk("rst almost_empty", bus.almost_empty, 2'b11);
      chk("rst almost_full",  bus.almost_full,  2'b00);
      chk("rst pause",        bus.pause,        1'b0);
      chk("rst data_out",     bus.data_out,     12'h000);
      do_init();

      // one word to each destination
      drive(1'b1, 6'b000101, '0);
      chk("push d0 active", {idle_o, act_o, err_o}, 3'b010);
      drive(1'b1, 6'b100010, '0);
      chk("two pushes empty",  bus.empty,        2'b00);
      chk("two pushes ae",     bus.almost_empty, 2'b11);
      chk("two pushes active", {idle_o, act_o, err_o}, 3'b010);
      drive(1'b0, '0, 2'b11);
      chk("pop both data_out", bus.data_out, {6'b100010, 6'b000101});
      chk("drained idle", {idle_o, act_o, err_o}, 3'b100);

      // fill D0 to the almost-full margin and beyond
      for (int k = 1; k <= 6; k++) drive(1'b1, DW'(k), '0);
      chk("count6 almost_full", bus.almost_full, 2'b00);
      drive(1'b1, DW'(7), '0);
      chk("count7 almost_full", bus.almost_full, 2'b01);
      chk("count7 pause",       bus.pause,       1'b1);
      drive(1'b1, DW'(8), '0);
      chk("count8 empty", bus.empty, 2'b10);
      chk("count8 error", bus.error, 2'b00);
      drive(1'b1, DW'(9), 2'b01);
      chk("full push+pop head",  bus.data_out[DW-1:0], DW'(1));
      chk("full push+pop error", bus.error,            2'b00);

      // overflow: word dropped, further pushes ignored in ERROR
      drive(1'b1, DW'(10), '0);
      chk("overflow error",  bus.error, 2'b01);
      chk("overflow status", {idle_o, act_o, err_o}, 3'b001);
      drive(1'b1, DW'(11), '0);
      for (int k = 2; k <= 9; k++) begin
         drive(1'b0, '0, 2'b01);
         chk("drain after overflow", bus.data_out[DW-1:0], DW'(k));
      end
      chk("drain leaves empty", bus.empty, 2'b11);

      // underflow on D1 from ACTIVE
      do_init();
      drive(1'b1, 6'h03, '0);
      drive(1'b0, '0, 2'b10);
      chk("underflow error",  bus.error, 2'b10);
      chk("underflow status", {idle_o, act_o, err_o}, 3'b001);
      if (HAS_CLR) begin
         err_clr = 1'b1;
         drive(1'b0, '0, '0);
         err_clr = 1'b0;
         chk("err_clr status", {idle_o, act_o, err_o}, 3'b100);
         chk("err_clr empty",  bus.empty, 2'b11);
         chk("err_clr error",  bus.error, 2'b00);
      end else begin
         repeat (2) drive(1'b0, '0, '0);
         chk("error sticky", {idle_o, act_o, err_o}, 3'b001);
      end

      // fill both destinations, then drain together
      do_init();
      for (int k = 0; k < DEPTH; k++) begin
         drive(1'b1, DW'(k), '0);
         drive(1'b1, DW'(32 + k), '0);
      end
      chk("both full empty", bus.empty,       2'b00);
      chk("both full af",    bus.almost_full, 2'b11);
      for (int k = 0; k < DEPTH; k++) begin
         drive(1'b0, '0, 2'b11);
         chk("drain order", bus.data_out, {DW'(32 + k), DW'(k)});
         if (k == DEPTH - 1) chk("idle after last pop", {idle_o, act_o, err_o}, 3'b100);
         else                chk("active while draining", {idle_o, act_o, err_o}, 3'b010);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
